// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: sizes, FSM state encoding and
// the block-fill address helper.
package mem_arbiter_pkg;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 16;
    localparam int WORDS      = 8;
    localparam int BLK_OFF_W  = 4;
    localparam int WORD_IDX_W = 3;
    localparam int CNT_W      = 4;

    // Issue counter runs 0..WORDS; reaching WORDS means all reads are out.
    localparam logic [CNT_W-1:0]      IC_END  = CNT_W'(WORDS);
    // Receive counter value of the final beat of a block.
    localparam logic [WORD_IDX_W-1:0] RC_LAST = WORD_IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_FILL_I = 2'd2,
        ST_FILL_D = 2'd3
    } arb_state_e;

    // Byte address of word idx inside the block holding addr; the low
    // block-offset bits of addr are discarded so they never leak out.
    function automatic logic [ADDR_W-1:0] word_addr(
        input logic [ADDR_W-1:0]     addr,
        input logic [WORD_IDX_W-1:0] idx
    );
        return {addr[ADDR_W-1:BLK_OFF_W], idx, 1'b0};
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side signal bundle of the memory arbiter.
// slave: the arbiter's view; master: the caches/memory (or bench) view.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic              i_miss;
    logic [ADDR_W-1:0] i_miss_addr;
    logic              d_miss;
    logic [ADDR_W-1:0] d_miss_addr;
    logic              d_wr_req;
    logic [ADDR_W-1:0] d_wr_addr;
    logic [DATA_W-1:0] d_wr_data;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_data_valid;

    logic                  mem_enable;
    logic                  mem_wr;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_data_out;
    logic [DATA_W-1:0]     fill_data;
    logic [WORD_IDX_W-1:0] fill_word;
    logic                  i_fill_we;
    logic                  d_fill_we;
    logic                  i_tag_we;
    logic                  d_tag_we;
    logic                  i_done;
    logic                  d_done;
    logic                  d_wr_done;
    logic                  busy;

    modport slave (
        input  i_miss, i_miss_addr, d_miss, d_miss_addr,
               d_wr_req, d_wr_addr, d_wr_data, mem_data_in, mem_data_valid,
        output mem_enable, mem_wr, mem_addr, mem_data_out,
               fill_data, fill_word, i_fill_we, d_fill_we,
               i_tag_we, d_tag_we, i_done, d_done, d_wr_done, busy
    );

    modport master (
        output i_miss, i_miss_addr, d_miss, d_miss_addr,
               d_wr_req, d_wr_addr, d_wr_data, mem_data_in, mem_data_valid,
        input  mem_enable, mem_wr, mem_addr, mem_data_out,
               fill_data, fill_word, i_fill_we, d_fill_we,
               i_tag_we, d_tag_we, i_done, d_done, d_wr_done, busy
    );

endinterface

// File: rtl/mem_arbiter.sv
// Memory arbiter: serves write-through stores and I/D block fills against a
// pipelined main memory. Fills issue 8 reads back-to-back and complete by
// counting returned valids, so any memory latency is tolerated.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    mem_arbiter_if.slave bus
);

    arb_state_e            state_q, state_d;
    logic [CNT_W-1:0]      ic_q, ic_d;
    logic [WORD_IDX_W-1:0] rc_q, rc_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;

    logic              mem_enable_s;
    logic              mem_wr_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [DATA_W-1:0] mem_data_out_s;
    logic              fill_we_s;
    logic              last_beat_s;

    // State, counters and latched request; async reset drops any fill in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ic_q    <= '0;
            rc_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ic_q    <= ic_d;
            rc_q    <= rc_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Arbitration, read issue, beat receive and completion decode.
    always_comb begin
        state_d        = state_q;
        ic_d           = ic_q;
        rc_d           = rc_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        mem_enable_s   = 1'b0;
        mem_wr_s       = 1'b0;
        mem_addr_s     = '0;
        mem_data_out_s = '0;
        fill_we_s      = 1'b0;
        last_beat_s    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ic_d = '0;
                rc_d = '0;
                // Stores first so write-through never waits behind a fill.
                if (bus.d_wr_req) begin
                    state_d = ST_WRITE;
                    addr_d  = bus.d_wr_addr;
                    wdata_d = bus.d_wr_data;
                end else if (bus.d_miss) begin
                    state_d = ST_FILL_D;
                    addr_d  = bus.d_miss_addr;
                end else if (bus.i_miss) begin
                    state_d = ST_FILL_I;
                    addr_d  = bus.i_miss_addr;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_WRITE: begin
                mem_enable_s   = 1'b1;
                mem_wr_s       = 1'b1;
                mem_addr_s     = addr_q;
                mem_data_out_s = wdata_q;
                state_d        = ST_IDLE;
            end

            ST_FILL_I, ST_FILL_D: begin
                if (ic_q < IC_END) begin
                    mem_enable_s = 1'b1;
                    mem_addr_s   = word_addr(addr_q, ic_q[WORD_IDX_W-1:0]);
                    ic_d         = ic_q + 4'd1;
                end else begin
                    ic_d = ic_q;
                end

                if (bus.mem_data_valid) begin
                    fill_we_s = 1'b1;
                    if (rc_q == RC_LAST) begin
                        last_beat_s = 1'b1;
                        state_d     = ST_IDLE;
                        ic_d        = '0;
                        rc_d        = '0;
                    end else begin
                        rc_d = rc_q + 3'd1;
                    end
                end else begin
                    rc_d = rc_q;
                end
            end

            default: begin
                state_d = ST_IDLE;
                ic_d    = '0;
                rc_d    = '0;
            end
        endcase
    end

    assign bus.mem_enable   = mem_enable_s;
    assign bus.mem_wr       = mem_wr_s;
    assign bus.mem_addr     = mem_addr_s;
    assign bus.mem_data_out = mem_data_out_s;

    // Fill data is gated so nothing but a real beat reaches the caches.
    assign bus.fill_data = fill_we_s ? bus.mem_data_in : '0;
    assign bus.fill_word = fill_we_s ? rc_q : '0;

    assign bus.i_fill_we = fill_we_s & (state_q == ST_FILL_I);
    assign bus.d_fill_we = fill_we_s & (state_q == ST_FILL_D);
    assign bus.i_tag_we  = last_beat_s & (state_q == ST_FILL_I);
    assign bus.d_tag_we  = last_beat_s & (state_q == ST_FILL_D);
    assign bus.i_done    = last_beat_s & (state_q == ST_FILL_I);
    assign bus.d_done    = last_beat_s & (state_q == ST_FILL_D);
    assign bus.d_wr_done = (state_q == ST_WRITE);

    assign bus.busy = (state_q != ST_IDLE) | bus.i_miss | bus.d_miss | bus.d_wr_req;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a memory model returns word = address,
// stimulus pushes expected accesses and fill beats, a monitor pops/compares.
`timescale 1ns/1ps
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors   = 0;
    int checks   = 0;
    int cyc      = 0;
    int busy_low = 0;

    // Cycle number; cycle N spans posedge N .. posedge N+1.
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory model ----------------
    typedef struct { int due; logic [15:0] data; } beat_t;
    beat_t mq[$];
    int    last_due  = 0;
    int    n_issued  = 0;
    bit    gap_mode  = 1'b0;
    bit    spur      = 1'b0;
    int    lat_tab [8] = '{4, 7, 5, 6, 4, 7, 4, 5};

    // Pipelined in-order memory; keeps returning beats regardless of DUT reset.
    always @(negedge clk) begin
        int    lat;
        int    due;
        beat_t b;
        if (bus.mem_enable === 1'b1 && bus.mem_wr === 1'b0) begin
            lat = gap_mode ? lat_tab[n_issued % 8] : 4;
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq.push_back('{due, bus.mem_addr});
            n_issued++;
        end
        if (mq.size() > 0 && mq[0].due == cyc) begin
            b = mq.pop_front();
            bus.mem_data_valid = 1'b1;
            bus.mem_data_in    = b.data;
        end else if (spur) begin
            bus.mem_data_valid = 1'b1;
            bus.mem_data_in    = 16'hDEAD;
        end else begin
            bus.mem_data_valid = 1'b0;
            bus.mem_data_in    = 16'h0000;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct { bit wr; logic [15:0] addr; logic [15:0] data; int cyc; } acc_t;
    typedef struct { bit is_d; logic [2:0] word; logic [15:0] data; bit last; int cyc; } fill_t;
    acc_t  acc_q[$];
    fill_t fill_q[$];

    // Expected 8 reads + 8 beats of one block; c0 >= 0 pins exact cycles.
    task automatic exp_fill(input bit is_d, input logic [15:0] addr, input int c0);
        logic [15:0] base;
        base = addr & 16'hFFF0;
        for (int k = 0; k < 8; k++) begin
            acc_q.push_back('{1'b0, base + 16'(2 * k), 16'h0000, (c0 >= 0) ? c0 + 1 + k : -1});
            fill_q.push_back('{is_d, 3'(k), base + 16'(2 * k), (k == 7), (c0 >= 0) ? c0 + 5 + k : -1});
        end
    endtask

    // Monitor: compares every memory access and fill beat the DUT presents.
    always @(negedge clk) begin
        acc_t  ea;
        fill_t ef;
        logic  done_s;
        logic  tag_s;
        #1;
        if (bus.mem_enable === 1'b1) begin
            checks++;
            if (acc_q.size() == 0) begin
                errors++;
                $display("FAIL acc_unexpected: got wr=%b addr=%h at cyc %0d, expected no access",
                         bus.mem_wr, bus.mem_addr, cyc);
            end else begin
                ea = acc_q.pop_front();
                if (bus.mem_wr !== ea.wr || bus.mem_addr !== ea.addr ||
                    (ea.wr && (bus.mem_data_out !== ea.data || bus.d_wr_done !== 1'b1)) ||
                    (ea.cyc >= 0 && cyc != ea.cyc)) begin
                    errors++;
                    $display("FAIL acc: got wr=%b addr=%h data=%h wr_done=%b cyc=%0d, expected wr=%b addr=%h data=%h cyc=%0d",
                             bus.mem_wr, bus.mem_addr, bus.mem_data_out, bus.d_wr_done, cyc,
                             ea.wr, ea.addr, ea.data, ea.cyc);
                end
            end
        end
        if (bus.i_fill_we === 1'b1 || bus.d_fill_we === 1'b1) begin
            checks++;
            if (fill_q.size() == 0) begin
                errors++;
                $display("FAIL fill_unexpected: got i_we=%b d_we=%b word=%0d data=%h at cyc %0d, expected no beat",
                         bus.i_fill_we, bus.d_fill_we, bus.fill_word, bus.fill_data, cyc);
            end else begin
                ef = fill_q.pop_front();
                done_s = ef.is_d ? bus.d_done : bus.i_done;
                tag_s  = ef.is_d ? bus.d_tag_we : bus.i_tag_we;
                if (bus.d_fill_we !== ef.is_d || bus.i_fill_we !== !ef.is_d ||
                    bus.fill_word !== ef.word || bus.fill_data !== ef.data ||
                    done_s !== ef.last || tag_s !== ef.last ||
                    (ef.cyc >= 0 && cyc != ef.cyc)) begin
                    errors++;
                    $display("FAIL fill: got d=%b i=%b word=%0d data=%h done=%b tag=%b cyc=%0d, expected d=%b word=%0d data=%h last=%b cyc=%0d",
                             bus.d_fill_we, bus.i_fill_we, bus.fill_word, bus.fill_data, done_s, tag_s, cyc,
                             ef.is_d, ef.word, ef.data, ef.last, ef.cyc);
                end
            end
        end
        if (((bus.i_done | bus.i_tag_we) & ~bus.i_fill_we) === 1'b1 ||
            ((bus.d_done | bus.d_tag_we) & ~bus.d_fill_we) === 1'b1 ||
            (bus.d_wr_done & ~(bus.mem_enable & bus.mem_wr)) === 1'b1 ||
            (bus.i_fill_we & bus.d_fill_we) === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL stray_strobe: got i_done=%b d_done=%b i_tag=%b d_tag=%b wr_done=%b at cyc %0d, expected none",
                     bus.i_done, bus.d_done, bus.i_tag_we, bus.d_tag_we, bus.d_wr_done, cyc);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_pulse(input int which, input int budget, input string name);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            #2;
            if (bus.busy !== 1'b1) busy_low++;
            case (which)
                0:       seen = (bus.i_done === 1'b1);
                1:       seen = (bus.d_done === 1'b1);
                default: seen = (bus.d_wr_done === 1'b1);
            endcase
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL timeout_%s: got no pulse within %0d cycles, expected one", name, budget);
        end
    endtask

    task automatic check_all_zero(input string name);
        logic [60:0] v;
        v = {bus.mem_enable, bus.mem_wr, bus.mem_addr, bus.mem_data_out, bus.fill_data,
             bus.fill_word, bus.i_fill_we, bus.d_fill_we, bus.i_tag_we, bus.d_tag_we,
             bus.i_done, bus.d_done, bus.d_wr_done, bus.busy};
        checks++;
        if (v !== 61'd0) begin
            errors++;
            $display("FAIL zero_%s: got outputs=%h, expected 0", name, v);
        end
    endtask

    task automatic start_cycle(output int c0);
        @(negedge clk);
        c0 = cyc;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int c0;
        bus.i_miss      = 1'b0;
        bus.i_miss_addr = 16'h0000;
        bus.d_miss      = 1'b0;
        bus.d_miss_addr = 16'h0000;
        bus.d_wr_req    = 1'b0;
        bus.d_wr_addr   = 16'h0000;
        bus.d_wr_data   = 16'h0000;

        repeat (3) @(negedge clk);
        #3;
        check_all_zero("reset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // I-miss with unaligned address, fixed 4-cycle memory, exact timing.
        start_cycle(c0);
        exp_fill(1'b0, 16'h1236, c0);
        bus.i_miss_addr = 16'h1236;
        bus.i_miss      = 1'b1;
        wait_pulse(0, 40, "i_fill");
        bus.i_miss = 1'b0;
        repeat (3) @(negedge clk);

        // Simultaneous D and I miss: D first, I after; busy never drops.
        start_cycle(c0);
        exp_fill(1'b1, 16'h4000, c0);
        exp_fill(1'b0, 16'h5678, -1);
        busy_low        = 0;
        bus.d_miss_addr = 16'h4000;
        bus.i_miss_addr = 16'h5678;
        bus.d_miss      = 1'b1;
        bus.i_miss      = 1'b1;
        wait_pulse(1, 40, "dual_d");
        bus.d_miss = 1'b0;
        wait_pulse(0, 40, "dual_i");
        bus.i_miss = 1'b0;
        checks++;
        if (busy_low != 0) begin
            errors++;
            $display("FAIL dual_busy: got %0d cycles with busy low, expected 0", busy_low);
        end
        repeat (3) @(negedge clk);

        // Store beats a pending D miss; fill starts after the write completes.
        start_cycle(c0);
        acc_q.push_back('{1'b1, 16'h0010, 16'hBEEF, c0 + 1});
        exp_fill(1'b1, 16'h200F, c0 + 2);
        bus.d_wr_addr   = 16'h0010;
        bus.d_wr_data   = 16'hBEEF;
        bus.d_miss_addr = 16'h200F;
        bus.d_wr_req    = 1'b1;
        bus.d_miss      = 1'b1;
        wait_pulse(2, 10, "store");
        bus.d_wr_req = 1'b0;
        wait_pulse(1, 40, "store_fill");
        bus.d_miss = 1'b0;
        repeat (3) @(negedge clk);

        // Reset at cycle 7 of a fill: 6 reads out, 2 beats in, 4 still coming.
        start_cycle(c0);
        for (int k = 0; k < 6; k++) begin
            acc_q.push_back('{1'b0, 16'h3000 + 16'(2 * k), 16'h0000, c0 + 1 + k});
        end
        for (int k = 0; k < 2; k++) begin
            fill_q.push_back('{1'b0, 3'(k), 16'h3000 + 16'(2 * k), 1'b0, c0 + 5 + k});
        end
        bus.i_miss_addr = 16'h3004;
        bus.i_miss      = 1'b1;
        do begin
            @(posedge clk);
            #2;
        end while (cyc < c0 + 7);
        rst_n      = 1'b0;
        bus.i_miss = 1'b0;
        @(negedge clk);
        #3;
        check_all_zero("rst_mid_a");
        @(negedge clk);
        #3;
        check_all_zero("rst_mid_b");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #3;
        check_all_zero("after_rst");

        // Irregular memory latency: still 8 beats in order, done only on the 8th.
        gap_mode = 1'b1;
        start_cycle(c0);
        exp_fill(1'b1, 16'h6A5C, -1);
        bus.d_miss_addr = 16'h6A5C;
        bus.d_miss      = 1'b1;
        wait_pulse(1, 80, "gap_fill");
        bus.d_miss = 1'b0;
        gap_mode   = 1'b0;
        repeat (3) @(negedge clk);

        // Spurious valids while idle must not strobe anything.
        @(posedge clk);
        #2;
        spur = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #3;
            check_all_zero("spurious");
        end
        spur = 1'b0;

        // Drain: every expected event must have been seen.
        for (int n = 0; n < 50 && (acc_q.size() != 0 || fill_q.size() != 0); n++) begin
            @(negedge clk);
        end
        checks++;
        if (acc_q.size() != 0 || fill_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d accesses and %0d beats outstanding, expected 0 and 0",
                     acc_q.size(), fill_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
